// File: rtl/iir_sample_feeder.sv
// iir_sample_feeder: FIFO-buffered sample pacer that feeds x/a to an IIR filter once per rate period.
module iir_sample_feeder #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4,
  parameter int RATE_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          coef_in,
  input  logic                       coef_load,
  input  logic [RATE_W-1:0]          rate,
  output logic [DATA_W-1:0]          x,
  output logic [DATA_W-1:0]          a,
  output logic                       x_strobe,
  output logic                       underrun,
  output logic [$clog2(DEPTH):0]     fill
);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     head, tail;
  logic [RATE_W-1:0] cnt, rate_q;
  logic [DATA_W-1:0] shadow;
  logic              started, tick, push, pop;
  always_comb begin
    in_ready = fill < FW'(DEPTH);
    tick     = started && cnt == rate_q;
    push     = in_valid && in_ready;
    pop      = tick && fill != '0;
  end
  // started marks the first edge after release, where rate is sampled without ticking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started  <= 1'b0;
      cnt      <= '0;
      rate_q   <= '0;
      x        <= '0;
      a        <= '0;
      shadow   <= '0;
      x_strobe <= 1'b0;
      underrun <= 1'b0;
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
    end else begin
      started  <= 1'b1;
      cnt      <= (!started || tick) ? '0 : cnt + 1'b1;
      rate_q   <= (!started || tick) ? rate : rate_q;
      x_strobe <= pop;
      underrun <= tick && fill == '0;
      a        <= tick ? shadow : a;
      shadow   <= coef_load ? coef_in : shadow;
      x        <= pop ? mem[head] : x;
      head     <= pop ? head + 1'b1 : head;
      tail     <= push ? tail + 1'b1 : tail;
      fill     <= fill + FW'(push) - FW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_data;
  end
endmodule

// File: tb/tb_iir_sample_feeder.sv
// tb_iir_sample_feeder: vector table, directed corner sequences and randomized run against a queue-based model.
module tb_iir_sample_feeder;
  localparam int DW = 4, DEPTH = 4, RW = 4, FW = $clog2(DEPTH) + 1;
  logic          clk = 1'b0, rst = 1'b0;
  logic [DW-1:0] in_data = '0, coef_in = '0;
  logic          in_valid = 1'b0, coef_load = 1'b0;
  logic [RW-1:0] rate = '0;
  logic          in_ready, x_strobe, underrun;
  logic [DW-1:0] x, a;
  logic [FW-1:0] fill;
  int n_cmp = 0, n_bad = 0;
  int q[$];
  int mx, ma, msh, cyc, nxt;
  bit mstb, mund, mstarted;
  typedef struct {
    logic vld; logic [DW-1:0] din; logic cl; logic [DW-1:0] cin;
    int ex; int ea; int es; int eu; int ef;
  } vec_t;
  vec_t tbl[10];
  iir_sample_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .RATE_W(RW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .coef_in(coef_in), .coef_load(coef_load), .rate(rate), .x(x), .a(a),
    .x_strobe(x_strobe), .underrun(underrun), .fill(fill)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic model_reset();
    q.delete();
    mx = 0; ma = 0; msh = 0; mstb = 0; mund = 0; mstarted = 0; cyc = 0; nxt = 0;
  endtask
  // ticks are scheduled by absolute edge number: rate+1 edges after the previous tick or start edge
  task automatic model_edge();
    bit tick, push;
    tick = mstarted && cyc == nxt;
    push = in_valid && q.size() < DEPTH;
    mstb = 0; mund = 0;
    if (tick) begin
      if (q.size() > 0) begin mx = q.pop_front(); mstb = 1; end
      else mund = 1;
      ma = msh;
      nxt = cyc + int'(rate) + 1;
    end
    if (!mstarted) begin mstarted = 1; nxt = cyc + int'(rate) + 1; end
    if (push) q.push_back(int'(in_data));
    if (coef_load) msh = int'(coef_in);
    cyc++;
  endtask
  task automatic check_model(input string nm);
    bit ok;
    ok = int'(x) === mx && int'(a) === ma && x_strobe === mstb && underrun === mund &&
         int'(fill) === q.size() && in_ready === (q.size() < DEPTH);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got x=%0d a=%0d stb=%0b und=%0b fill=%0d rdy=%0b expected x=%0d a=%0d stb=%0b und=%0b fill=%0d rdy=%0b",
               nm, x, a, x_strobe, underrun, fill, in_ready, mx, ma, mstb, mund, q.size(), q.size() < DEPTH);
    end
  endtask
  task automatic step(input string nm);
    model_edge();
    @(posedge clk);
    #1;
    check_model(nm);
  endtask
  task automatic do_reset(input logic [RW-1:0] r);
    in_valid = 0; coef_load = 0; rate = r; rst = 0;
    @(posedge clk);
    #1;
    model_reset();
    check_model("reset_state");
    @(negedge clk);
    rst = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    int nstb, maxf, nxt_d;
    bit acc;
    int got[$];
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 2, 0, 0, 0, 0, 0, 1, 1};
    tbl[2] = '{1, 1, 0, 0, 2, 0, 1, 0, 1};
    tbl[3] = '{1, 7, 0, 0, 1, 0, 1, 0, 1};
    tbl[4] = '{0, 0, 0, 0, 7, 0, 1, 0, 0};
    tbl[5] = '{0, 0, 1, 2, 7, 0, 0, 1, 0};
    tbl[6] = '{0, 0, 1, 7, 7, 2, 0, 1, 0};
    tbl[7] = '{0, 0, 0, 0, 7, 7, 0, 1, 0};
    tbl[8] = '{1, 3, 1, 4, 7, 7, 0, 1, 1};
    tbl[9] = '{0, 0, 0, 0, 3, 4, 1, 0, 0};
    do_reset(0);
    for (int i = 0; i < 10; i++) begin
      in_valid = tbl[i].vld; in_data = tbl[i].din; coef_load = tbl[i].cl; coef_in = tbl[i].cin;
      step($sformatf("tbl%0d_model", i));
      chk($sformatf("tbl%0d_vec", i), int'({x, a, x_strobe, underrun, fill}),
          (tbl[i].ex << 9) | (tbl[i].ea << 5) | (tbl[i].es << 4) | (tbl[i].eu << 3) | tbl[i].ef);
    end
    coef_load = 0; in_valid = 0;
    do_reset(3);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = DW'(i + 1);
      step("preload");
    end
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_fill", int'(fill), 4);
    in_valid = 0;
    step("first_pop");
    chk("first_pop_in_ready", int'(in_ready), 1);
    chk("first_pop_x", int'(x), 1);
    nstb = int'(x_strobe);
    for (int i = 0; i < 11; i++) begin
      step("rate3_run");
      nstb += int'(x_strobe);
    end
    chk("rate3_strobe_count", nstb, 3);
    chk("rate3_last_x", int'(x), 3);
    do_reset(1);
    nxt_d = 1; maxf = 0;
    for (int k = 0; k < 80 && got.size() < 10; k++) begin
      in_valid = nxt_d <= 10; in_data = DW'(nxt_d);
      acc = in_valid && in_ready;
      step("stream");
      if (acc) nxt_d++;
      if (x_strobe) got.push_back(int'(x));
      if (int'(fill) > maxf) maxf = int'(fill);
    end
    in_valid = 0;
    chk("stream_count", got.size(), 10);
    foreach (got[i]) chk($sformatf("stream_order%0d", i), got[i], i + 1);
    chk("stream_fill_bounded", int'(maxf <= DEPTH), 1);
    do_reset(0);
    coef_load = 1; coef_in = 5; in_valid = 1; in_data = 9;
    step("mid_push9");
    coef_load = 0; in_valid = 0; rate = 7;
    step("mid_pop9");
    for (int i = 3; i < 6; i++) begin
      in_valid = 1; in_data = DW'(i);
      step("mid_fill");
    end
    in_valid = 0;
    chk("mid_fill3", int'(fill), 3);
    chk("mid_x9_a5", int'({x, a}), (9 << 4) | 5);
    #2 rst = 0;
    #1;
    chk("async_rst_outs", int'({x, a, x_strobe, underrun, fill}), 0);
    chk("async_rst_in_ready", int'(in_ready), 1);
    model_reset();
    @(negedge clk);
    rst = 1; rate = 0;
    nstb = 0;
    for (int i = 0; i < 12; i++) begin
      step("post_rst_idle");
      nstb += int'(x_strobe);
    end
    chk("post_rst_no_strobe", nstb, 0);
    do_reset(RW'($urandom_range(0, 3)));
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 2) != 0;
      in_data = DW'($urandom);
      coef_load = $urandom_range(0, 7) == 0;
      coef_in = DW'($urandom);
      if ($urandom_range(0, 15) == 0) rate = RW'($urandom_range(0, 3));
      step("random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/iir_sample_feeder.md
IIR_SAMPLE_FEEDER -- requirements
Module: iir_sample_feeder

Interface
REQ-001 Parameter DATA_W, default 4: width of each sample and coefficient, matching the filter's x/a inputs.
REQ-002 Parameter DEPTH, default 4: number of sample FIFO entries, a power of two.
REQ-003 Parameter RATE_W, default 4: width of the rate control input.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  DATA_W  upstream sample.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  feeder accepts a sample this cycle.
REQ-009 coef_in  input  DATA_W  new filter coefficient.
REQ-010 coef_load  input  1  one-cycle strobe that captures coef_in.
REQ-011 rate  input  RATE_W  sample period minus one, in clk cycles.
REQ-012 x  output  DATA_W  registered sample to the filter's x input.
REQ-013 a  output  DATA_W  registered coefficient to the filter's a input.
REQ-014 x_strobe  output  1  one-cycle pulse: x (and a) updated this cycle.
REQ-015 underrun  output  1  one-cycle pulse: a sample tick found the FIFO empty.
REQ-016 fill  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Function
REQ-017 in_ready SHALL equal (fill < DEPTH), derived from registered state only, with no combinational path from in_valid.
REQ-018 A push SHALL occur on a rising edge where in_valid=1 and in_ready=1; in_data is written at the tail.
REQ-019 A rate counter SHALL count from 0; a tick SHALL occur in the cycle where counter == rate_latched; on a tick the counter returns to 0, otherwise it increments.
REQ-020 rate_latched SHALL be loaded from rate at reset release and at every tick, so a rate change takes effect from the next period.
REQ-021 rate=0 SHALL produce a tick every cycle; rate=R SHALL produce a tick every R+1 cycles.
REQ-022 On a tick with fill>0, the FIFO head SHALL be popped into x, and x_strobe SHALL be 1 in the following cycle, concurrent with the new x. Latency from tick to x valid is 1 cycle.
REQ-023 On a tick with fill==0, x SHALL hold its previous value, x_strobe SHALL stay 0, and underrun SHALL pulse for 1 cycle, aligned as x_strobe would be.
REQ-024 A push and a tick in the same cycle with fill==0 SHALL be handled as follows: the tick underruns (no fall-through), and the pushed sample is stored, giving fill=1.
REQ-025 A push and a pop in the same cycle SHALL leave fill unchanged, preserving FIFO order.
REQ-026 Head and tail pointers SHALL wrap modulo DEPTH; fill SHALL never exceed DEPTH or go below 0.
REQ-027 coef_load=1 SHALL capture coef_in into a shadow register on that edge.
REQ-028 Output a SHALL load from the shadow register on every tick, whether that tick pops a sample or underruns, so a changes only in step with x updates.
REQ-029 When coef_load and a tick occur in the same cycle, a SHALL take the old shadow value, and the new coefficient SHALL appear at the next tick.
REQ-030 All arithmetic SHALL be unsigned; samples pass through unmodified, with no scaling or saturation.

Reset
REQ-031 While rst=0, regardless of clk, the block SHALL hold: x=0, a=0, shadow=0, x_strobe=0, underrun=0, fill=0, pointers=0, counter=0, rate_latched=0.
REQ-032 With rst=0, in_ready SHALL be 1 (fill=0).
REQ-033 Reset asserted mid-operation SHALL discard all FIFO contents and any pending coefficient immediately.
REQ-034 After rst returns high, the first tick SHALL occur rate+1 cycles later, with rate sampled at the first rising edge after release.

Verification
REQ-035 Setup: reset, rate=0, push 2,1,7 on consecutive cycles. Required response: x = 2,1,7 on x_strobe pulses; then an underrun pulse on the next tick, with x held at 7.
REQ-036 Setup: rate=3, FIFO preloaded with 4 samples. Required response: x_strobe every 4 cycles; in_ready=0 while fill=4; in_ready=1 the cycle after the first pop.
REQ-037 Setup: in_valid held high with rate=1, supplying 1..10. Required response: all 10 samples emerge in order, pointer wrap is exercised, and fill never exceeds 4.
REQ-038 Setup: coef_in=2 loaded, then coef_in=7 loaded in the same cycle as a tick. Required response: a=2 at that tick's x_strobe and a=7 at the next.
REQ-039 Setup: empty FIFO, push coinciding with a tick. Required response: underrun=1, fill=1, and the sample appears at the following tick.
REQ-040 Setup: assert rst mid-stream with fill=3. Required response: all outputs go to 0 asynchronously, fill=0, and there is no x_strobe until new samples are pushed.
